battleship_game_ctrl: RTL and testbench

//  Parametrised N x N Battleship game controller: ship-count decision, player placement,

---
 rtl/battleship_pkg.sv | 24 ++
 rtl/battleship_lfsr.sv | 28 ++
 rtl/battleship_game_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_battleship_game_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared types for the Battleship controller: game states, cell encodings and
// the flat board index helper.
package battleship_pkg;

    typedef enum logic [2:0] {
        DECIDE      = 3'd0,
        PLACE       = 3'd1,
        PC_SETUP    = 3'd2,
        PLAYER_TURN = 3'd3,
        PC_TURN     = 3'd4,
        VICTORY     = 3'd5,
        DEFEAT      = 3'd6
    } game_state_t;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_MISS  = 2'b10;
    localparam logic [1:0] CELL_HIT   = 2'b11;

    function automatic int cell_idx(input int i, input int j, input int n);
        return i * n + j;
    endfunction

endpackage

// File: rtl/battleship_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) free-running from reset; exposes the
// low bits as a candidate (row, col) pair for PC placement and PC shots.
module battleship_lfsr #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          COORD_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    output logic [COORD_W-1:0] rnd_i,
    output logic [COORD_W-1:0] rnd_j
);

    logic [15:0] value;
    logic        feedback;

    assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];
    assign rnd_i    = value[COORD_W-1:0];
    assign rnd_j    = value[2*COORD_W-1:COORD_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= SEED;
        end else begin
            value <= {value[14:0], feedback};
        end
    end

endmodule

// File: rtl/battleship_game_ctrl.sv
// N x N Battleship controller: ship-count decision, player and PC placement,
// alternating shots, hit tracking and the terminal victory/defeat states.
module battleship_game_ctrl
    import battleship_pkg::*;
#(
    parameter int          N             = 5,
    parameter int          MAX_SHIPS     = 5,
    parameter int          PC_DELAY      = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          SHOW_PC_SHIPS = 0,
    localparam int         COORD_W       = $clog2(N),
    localparam int         CNT_W         = $clog2(MAX_SHIPS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   ships_req,
    input  logic               confirm_amount,
    input  logic [COORD_W-1:0] cur_i,
    input  logic [COORD_W-1:0] cur_j,
    input  logic               confirm_place,
    input  logic               fire,
    output logic [2:0]         state,
    output logic [2*N*N-1:0]   player_board,
    output logic [2*N*N-1:0]   pc_view,
    output logic [CNT_W-1:0]   ships_target,
    output logic [CNT_W-1:0]   player_left,
    output logic [CNT_W-1:0]   pc_left,
    output logic               move_error,
    output logic               shot_valid,
    output logic               shot_hit,
    output logic               victory,
    output logic               defeat
);

    localparam int BW    = 2 * N * N;
    localparam int OFF_W = $clog2(BW);
    localparam int DLY_W = (PC_DELAY < 1) ? 1 : $clog2(PC_DELAY + 1);

    // Strobes (confirm_amount, confirm_place, fire in; move_error, shot_valid,
    // shot_hit out) are single-cycle; an input strobe acts only in the state that consumes it.
    game_state_t        state_q, state_d;
    logic [BW-1:0]      pc_board, pc_board_d, player_board_d, pc_view_d;
    logic [CNT_W-1:0]   placed, placed_d, pc_placed, pc_placed_d;
    logic [CNT_W-1:0]   ships_target_d, player_left_d, pc_left_d;
    logic [DLY_W-1:0]   delay_cnt, delay_cnt_d;
    logic               move_error_d, shot_valid_d, shot_hit_d, victory_d, defeat_d;

    logic [COORD_W-1:0] rnd_i, rnd_j;
    logic [OFF_W-1:0]   cur_off, rnd_off;
    logic               cur_ok, rnd_ok;
    logic [1:0]         cur_pl_cell, cur_pc_cell, rnd_pl_cell, rnd_pc_cell;

    battleship_lfsr #(
        .SEED    (LFSR_SEED),
        .COORD_W (COORD_W)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .rnd_i (rnd_i),
        .rnd_j (rnd_j)
    );

    // Offsets are only meaningful when the matching *_ok flag is set.
    assign cur_ok      = (int'(cur_i) < N) && (int'(cur_j) < N);
    assign rnd_ok      = (int'(rnd_i) < N) && (int'(rnd_j) < N);
    assign cur_off     = OFF_W'(2 * cell_idx(int'(cur_i), int'(cur_j), N));
    assign rnd_off     = OFF_W'(2 * cell_idx(int'(rnd_i), int'(rnd_j), N));
    assign cur_pl_cell = player_board[cur_off +: 2];
    assign cur_pc_cell = pc_board[cur_off +: 2];
    assign rnd_pl_cell = player_board[rnd_off +: 2];
    assign rnd_pc_cell = pc_board[rnd_off +: 2];
    assign state       = state_q;

    always_comb begin
        state_d        = state_q;
        player_board_d = player_board;
        pc_board_d     = pc_board;
        ships_target_d = ships_target;
        placed_d       = placed;
        pc_placed_d    = pc_placed;
        player_left_d  = player_left;
        pc_left_d      = pc_left;
        delay_cnt_d    = delay_cnt;
        victory_d      = victory;
        defeat_d       = defeat;
        move_error_d   = 1'b0;
        shot_valid_d   = 1'b0;
        shot_hit_d     = 1'b0;
        pc_view_d      = '0;

        case (state_q)
            DECIDE: begin
                if (confirm_amount) begin
                    if (ships_req == '0) begin
                        ships_target_d = CNT_W'(1);
                    end else if (ships_req > CNT_W'(MAX_SHIPS)) begin
                        ships_target_d = CNT_W'(MAX_SHIPS);
                    end else begin
                        ships_target_d = ships_req;
                    end
                    placed_d = '0;
                    state_d  = PLACE;
                end
            end
            PLACE: begin
                if (confirm_place) begin
                    if (cur_ok && cur_pl_cell == CELL_EMPTY) begin
                        player_board_d[cur_off +: 2] = CELL_SHIP;
                        placed_d = placed + CNT_W'(1);
                        if (placed + CNT_W'(1) == ships_target) begin
                            player_left_d = ships_target;
                            pc_placed_d   = '0;
                            state_d       = PC_SETUP;
                        end
                    end else begin
                        move_error_d = 1'b1;
                    end
                end
            end
            PC_SETUP: begin
                if (rnd_ok && rnd_pc_cell == CELL_EMPTY) begin
                    pc_board_d[rnd_off +: 2] = CELL_SHIP;
                    pc_placed_d = pc_placed + CNT_W'(1);
                    if (pc_placed + CNT_W'(1) == ships_target) begin
                        pc_left_d = ships_target;
                        state_d   = PLAYER_TURN;
                    end
                end
            end
            PLAYER_TURN: begin
                if (fire) begin
                    if (cur_ok && !cur_pc_cell[1]) begin
                        shot_valid_d = 1'b1;
                        delay_cnt_d  = '0;
                        state_d      = PC_TURN;
                        if (cur_pc_cell == CELL_SHIP) begin
                            pc_board_d[cur_off +: 2] = CELL_HIT;
                            shot_hit_d = 1'b1;
                            pc_left_d  = pc_left - CNT_W'(1);
                            if (pc_left == CNT_W'(1)) begin
                                victory_d = 1'b1;
                                state_d   = VICTORY;
                            end
                        end else begin
                            pc_board_d[cur_off +: 2] = CELL_MISS;
                        end
                    end else begin
                        move_error_d = 1'b1;
                    end
                end
            end
            PC_TURN: begin
                // Hold for PC_DELAY cycles, then try one LFSR candidate per cycle.
                if (delay_cnt < DLY_W'(PC_DELAY)) begin
                    delay_cnt_d = delay_cnt + DLY_W'(1);
                end else if (rnd_ok && !rnd_pl_cell[1]) begin
                    shot_valid_d = 1'b1;
                    state_d      = PLAYER_TURN;
                    if (rnd_pl_cell == CELL_SHIP) begin
                        player_board_d[rnd_off +: 2] = CELL_HIT;
                        shot_hit_d    = 1'b1;
                        player_left_d = player_left - CNT_W'(1);
                        if (player_left == CNT_W'(1)) begin
                            defeat_d = 1'b1;
                            state_d  = DEFEAT;
                        end
                    end else begin
                        player_board_d[rnd_off +: 2] = CELL_MISS;
                    end
                end
            end
            VICTORY, DEFEAT: begin
            end
            default: begin
            end
        endcase

        for (int c = 0; c < N * N; c++) begin
            if (SHOW_PC_SHIPS == 0 && pc_board_d[2*c +: 2] == CELL_SHIP) begin
                pc_view_d[2*c +: 2] = CELL_EMPTY;
            end else begin
                pc_view_d[2*c +: 2] = pc_board_d[2*c +: 2];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= DECIDE;
            player_board <= '0;
            pc_board     <= '0;
            pc_view      <= '0;
            ships_target <= '0;
            placed       <= '0;
            pc_placed    <= '0;
            player_left  <= '0;
            pc_left      <= '0;
            delay_cnt    <= '0;
            move_error   <= 1'b0;
            shot_valid   <= 1'b0;
            shot_hit     <= 1'b0;
            victory      <= 1'b0;
            defeat       <= 1'b0;
        end else begin
            state_q      <= state_d;
            player_board <= player_board_d;
            pc_board     <= pc_board_d;
            pc_view      <= pc_view_d;
            ships_target <= ships_target_d;
            placed       <= placed_d;
            pc_placed    <= pc_placed_d;
            player_left  <= player_left_d;
            pc_left      <= pc_left_d;
            delay_cnt    <= delay_cnt_d;
            move_error   <= move_error_d;
            shot_valid   <= shot_valid_d;
            shot_hit     <= shot_hit_d;
            victory      <= victory_d;
            defeat       <= defeat_d;
        end
    end

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Directed-plus-random bench for battleship_game_ctrl, checked every cycle against
// a game-rules model held as 2-D board arrays.
module tb_battleship_game_ctrl;
    import battleship_pkg::*;

    localparam int          N         = 5;
    localparam int          MAX_SHIPS = 5;
    localparam int          PC_DELAY  = 2;
    localparam int          CW        = 3;
    localparam int          KW        = 3;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [KW-1:0] ships_req = '0;
    logic          confirm_amount = 1'b0;
    logic [CW-1:0] cur_i = '0;
    logic [CW-1:0] cur_j = '0;
    logic          confirm_place = 1'b0;
    logic          fire = 1'b0;

    logic [2:0]       state;
    logic [2*N*N-1:0] player_board, pc_view;
    logic [KW-1:0]    ships_target, player_left, pc_left;
    logic             move_error, shot_valid, shot_hit, victory, defeat;

    battleship_game_ctrl #(
        .N (N), .MAX_SHIPS (MAX_SHIPS), .PC_DELAY (PC_DELAY),
        .LFSR_SEED (SEED), .SHOW_PC_SHIPS (1)
    ) dut (
        .clk (clk), .rst (rst), .ships_req (ships_req),
        .confirm_amount (confirm_amount), .cur_i (cur_i), .cur_j (cur_j),
        .confirm_place (confirm_place), .fire (fire), .state (state),
        .player_board (player_board), .pc_view (pc_view),
        .ships_target (ships_target), .player_left (player_left), .pc_left (pc_left),
        .move_error (move_error), .shot_valid (shot_valid), .shot_hit (shot_hit),
        .victory (victory), .defeat (defeat)
    );

    always #5 clk = ~clk;

    game_state_t m_state;
    int m_pb[N][N];
    int m_pc[N][N];
    int m_target, m_placed, m_pcplaced, m_pl_left, m_pc_left, m_wait, m_lfsr;
    bit m_err, m_sv, m_sh, m_vic, m_def;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_state = DECIDE;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            m_pb[i][j] = 0;
            m_pc[i][j] = 0;
        end
        m_target = 0; m_placed = 0; m_pcplaced = 0; m_pl_left = 0; m_pc_left = 0;
        m_wait = 0; m_lfsr = int'(SEED);
        m_err = 0; m_sv = 0; m_sh = 0; m_vic = 0; m_def = 0;
    endtask

    // One clock edge of game rules, using the inputs presented before the edge.
    task automatic m_step();
        int ri, rj, ci, cj, q, fb;
        m_err = 0; m_sv = 0; m_sh = 0;
        ri = m_lfsr & 7;
        rj = (m_lfsr >> 3) & 7;
        ci = int'(cur_i);
        cj = int'(cur_j);
        case (m_state)
            DECIDE: if (confirm_amount) begin
                q = int'(ships_req);
                m_target = (q == 0) ? 1 : ((q > MAX_SHIPS) ? MAX_SHIPS : q);
                m_state = PLACE;
            end
            PLACE: if (confirm_place) begin
                if (ci < N && cj < N && m_pb[ci][cj] == 0) begin
                    m_pb[ci][cj] = 1;
                    m_placed++;
                    if (m_placed == m_target) begin
                        m_state = PC_SETUP;
                        m_pl_left = m_target;
                    end
                end else m_err = 1;
            end
            PC_SETUP: if (ri < N && rj < N && m_pc[ri][rj] == 0) begin
                m_pc[ri][rj] = 1;
                m_pcplaced++;
                if (m_pcplaced == m_target) begin
                    m_state = PLAYER_TURN;
                    m_pc_left = m_target;
                end
            end
            PLAYER_TURN: if (fire) begin
                if (ci < N && cj < N && m_pc[ci][cj] < 2) begin
                    m_sv = 1;
                    m_wait = 0;
                    m_state = PC_TURN;
                    if (m_pc[ci][cj] == 1) begin
                        m_pc[ci][cj] = 3;
                        m_sh = 1;
                        m_pc_left--;
                        if (m_pc_left == 0) begin
                            m_state = VICTORY;
                            m_vic = 1;
                        end
                    end else m_pc[ci][cj] = 2;
                end else m_err = 1;
            end
            PC_TURN: begin
                if (m_wait < PC_DELAY) m_wait++;
                else if (ri < N && rj < N && m_pb[ri][rj] < 2) begin
                    m_sv = 1;
                    m_state = PLAYER_TURN;
                    if (m_pb[ri][rj] == 1) begin
                        m_pb[ri][rj] = 3;
                        m_sh = 1;
                        m_pl_left--;
                        if (m_pl_left == 0) begin
                            m_state = DEFEAT;
                            m_def = 1;
                        end
                    end else m_pb[ri][rj] = 2;
                end
            end
            default: begin
            end
        endcase
        fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
    endtask

    task automatic check_all();
        logic [63:0] pb, pv;
        pb = '0;
        pv = '0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            pb[2*(i*N+j) +: 2] = 2'(m_pb[i][j]);
            pv[2*(i*N+j) +: 2] = 2'(m_pc[i][j]);
        end
        chk("state", 64'(state), 64'(m_state));
        chk("player_board", 64'(player_board), pb);
        chk("pc_view", 64'(pc_view), pv);
        chk("ships_target", 64'(ships_target), 64'(m_target));
        chk("player_left", 64'(player_left), 64'(m_pl_left));
        chk("pc_left", 64'(pc_left), 64'(m_pc_left));
        chk("move_error", 64'(move_error), 64'(m_err));
        chk("shot_valid", 64'(shot_valid), 64'(m_sv));
        chk("shot_hit", 64'(shot_hit), 64'(m_sh));
        chk("victory", 64'(victory), 64'(m_vic));
        chk("defeat", 64'(defeat), 64'(m_def));
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        check_all();
        fire = 1'b0;
        confirm_place = 1'b0;
        confirm_amount = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        m_reset();
        check_all();
        rst = 1'b0;
    endtask

    function automatic int pick_pc(input int kind);
        int c[$];
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            if ((kind == 0 && m_pc[i][j] == 1) || (kind == 1 && m_pc[i][j] == 0) ||
                (kind == 2 && m_pc[i][j] >= 2) || (kind == 3 && m_pc[i][j] < 2))
                c.push_back(i * N + j);
        end
        if (c.size() == 0) return -1;
        return c[$urandom_range(0, c.size() - 1)];
    endfunction

    function automatic int pick_pb(input int kind);
        int c[$];
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            if ((kind == 0 && m_pb[i][j] == 0) || (kind == 1 && m_pb[i][j] != 0))
                c.push_back(i * N + j);
        end
        if (c.size() == 0) return -1;
        return c[$urandom_range(0, c.size() - 1)];
    endfunction

    task automatic start_game(input int req);
        ships_req = KW'(req);
        confirm_amount = 1'b1;
        tick();
    endtask

    task automatic place_at(input int i, input int j);
        cur_i = CW'(i);
        cur_j = CW'(j);
        confirm_place = 1'b1;
        fire = ($urandom_range(0, 3) == 0);
        tick();
    endtask

    task automatic fire_at(input int i, input int j);
        cur_i = CW'(i);
        cur_j = CW'(j);
        fire = 1'b1;
        confirm_place = ($urandom_range(0, 3) == 0);
        tick();
    endtask

    // Tick with stray strobes until the model leaves state st.
    task automatic wait_leave(input game_state_t st, input int budget);
        int k = 0;
        while (m_state == st && k < budget) begin
            fire = ($urandom_range(0, 4) == 0);
            confirm_place = ($urandom_range(0, 4) == 0);
            confirm_amount = ($urandom_range(0, 4) == 0);
            cur_i = CW'($urandom_range(0, 7));
            cur_j = CW'($urandom_range(0, 7));
            tick();
            k++;
        end
        chk("wait_budget", 64'(k < budget), 64'd1);
    endtask

    task automatic place_random();
        int g = 0;
        int idx, r;
        while (m_state == PLACE && g < 200) begin
            r = $urandom_range(0, 5);
            idx = (r == 1) ? pick_pb(1) : pick_pb(0);
            if (r == 0 || idx < 0) place_at($urandom_range(0, 7), $urandom_range(0, 7));
            else place_at(idx / N, idx % N);
            g++;
        end
    endtask

    task automatic play_random(input int budget);
        int k = 0;
        int idx, r;
        while (k < budget && (m_state == PLAYER_TURN || m_state == PC_TURN)) begin
            if (m_state == PLAYER_TURN) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    fire_at($urandom_range(0, 7), $urandom_range(5, 7));
                end else begin
                    idx = (r == 1) ? pick_pc(2) : ((r <= 4) ? pick_pc(0) : pick_pc(1));
                    if (idx < 0) idx = pick_pc(3);
                    fire_at(idx / N, idx % N);
                end
            end else begin
                wait_leave(PC_TURN, 3000);
            end
            k++;
        end
    endtask

    initial begin
        int idx, k;
        do_reset();

        // Ship-count clamping at both ends.
        start_game(7);
        chk("clamp_high", 64'(ships_target), 64'd5);
        do_reset();
        start_game(0);
        chk("clamp_zero", 64'(ships_target), 64'd1);
        do_reset();

        // Duplicate and off-board placement, then a hit and a refire.
        start_game(2);
        place_at(2, 3);
        chk("place_cell", 64'(player_board[27:26]), 64'(CELL_SHIP));
        place_at(2, 3);
        chk("place_dup_err", 64'(move_error), 64'd1);
        chk("place_dup_state", 64'(state), 64'(PLACE));
        place_at(6, 1);
        chk("place_oob_err", 64'(move_error), 64'd1);
        idx = pick_pb(0);
        place_at(idx / N, idx % N);
        wait_leave(PC_SETUP, 3000);
        idx = pick_pc(0);
        fire_at(idx / N, idx % N);
        chk("hit_valid", 64'(shot_valid), 64'd1);
        chk("hit_flag", 64'(shot_hit), 64'd1);
        chk("hit_pc_left", 64'(pc_left), 64'd1);
        chk("hit_state", 64'(state), 64'(PC_TURN));
        wait_leave(PC_TURN, 3000);
        if (m_state == PLAYER_TURN) begin
            fire_at(idx / N, idx % N);
            chk("refire_err", 64'(move_error), 64'd1);
            chk("refire_state", 64'(state), 64'(PLAYER_TURN));
        end
        play_random(200);
        do_reset();

        // Reset while the PC is counting down its turn.
        start_game(3);
        place_random();
        wait_leave(PC_SETUP, 3000);
        idx = pick_pc(1);
        fire_at(idx / N, idx % N);
        tick();
        tick();
        do_reset();
        chk("rst_state", 64'(state), 64'(DECIDE));
        chk("rst_boards", 64'(player_board | pc_view), 64'd0);

        // Victory, then everything ignored.
        start_game(1);
        place_random();
        wait_leave(PC_SETUP, 3000);
        idx = pick_pc(0);
        fire_at(idx / N, idx % N);
        chk("victory_flag", 64'(victory), 64'd1);
        chk("victory_state", 64'(state), 64'(VICTORY));
        idx = pick_pc(3);
        confirm_amount = 1'b1;
        fire_at(idx / N, idx % N);
        chk("victory_hold", 64'(victory), 64'd1);
        chk("victory_ignore", 64'(shot_valid), 64'd0);
        do_reset();

        // Defeat: player only misses.
        start_game(1);
        place_random();
        wait_leave(PC_SETUP, 3000);
        k = 0;
        while (k < 40 && (m_state == PLAYER_TURN || m_state == PC_TURN)) begin
            if (m_state == PLAYER_TURN) begin
                idx = pick_pc(1);
                if (idx < 0) break;
                fire_at(idx / N, idx % N);
            end else begin
                wait_leave(PC_TURN, 3000);
            end
            k++;
        end
        chk("defeat_flag", 64'(defeat), 64'(m_def));
        chk("defeat_left", 64'(player_left), 64'(m_pl_left));
        do_reset();

        // Fully random games.
        for (int g = 0; g < 6; g++) begin
            start_game($urandom_range(0, 7));
            place_random();
            wait_leave(PC_SETUP, 3000);
            play_random(200);
            do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
